// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode, state and error encodings for the calculator sequencer
package calc_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_ILL = 3'd7
  } calc_op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_WB, ST_RSP} calc_state_e;
  typedef enum logic [1:0] {ERR_OK, ERR_DIVZ, ERR_TMO, ERR_ILL} calc_err_e;
  function automatic logic is_multicycle(input logic [2:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/calc_wait_timer.sv
// calc_wait_timer: WAIT-state cycle counter with clear, enable and terminal-count flag
module calc_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic                 l_clk,
  input  logic                 ff_rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);
  assign tc = cnt == CNT_WIDTH'(TIMEOUT - 1);
  always_ff @(posedge l_clk or posedge ff_rst)
    if (ff_rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: command sequencer for the calculator datapath; CALC_ACC_EN adds cmd_acc/acc_sel chaining
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic                  l_clk,
  input  logic                  ff_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_b,
`ifdef CALC_ACC_EN
  input  logic                  cmd_acc,
  output logic                  acc_sel,
`endif
  output logic                  opa_en,
  output logic                  opb_en,
  output logic                  res_en,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic                  alu_start,
  input  logic                  alu_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_err
);
  calc_state_e state;
  logic [CNT_WIDTH-1:0] cnt;
  logic tc, accept, ill, divz, go;
  assign accept = cmd_valid && cmd_ready;
  assign ill = cmd_op == OP_WIDTH'(OP_ILL);
  assign divz = cmd_op == OP_WIDTH'(OP_DIV) && cmd_b == '0;
  assign go = accept && !ill && !divz;
  assign opa_en = go;
  assign opb_en = go;
`ifdef CALC_ACC_EN
  assign acc_sel = go && cmd_acc;
`endif
  calc_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) u_timer (
    .l_clk (l_clk),
    .ff_rst(ff_rst),
    .clr   (state == ST_EXEC),
    .en    (state == ST_WAIT),
    .cnt   (cnt),
    .tc    (tc)
  );
  always_ff @(posedge l_clk or posedge ff_rst)
    if (ff_rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      alu_start <= 1'b0;
      res_en    <= 1'b0;
      rsp_valid <= 1'b0;
      alu_op    <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      alu_start <= 1'b0;
      res_en    <= 1'b0;
      case (state)
        ST_IDLE:
          if (accept) begin
            cmd_ready <= 1'b0;
            if (ill || divz) begin
              rsp_err   <= ill ? ERR_ILL : ERR_DIVZ;
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end else begin
              rsp_err   <= ERR_OK;
              alu_op    <= cmd_op;
              alu_start <= 1'b1;
              state     <= ST_EXEC;
            end
          end
        ST_EXEC:
          if (is_multicycle(alu_op)) state <= ST_WAIT;
          else begin
            res_en <= 1'b1;
            state  <= ST_WB;
          end
        ST_WAIT:
          if (alu_done) begin
            res_en <= 1'b1;
            state  <= ST_WB;
          end else if (tc) begin
            rsp_err   <= ERR_TMO;
            rsp_valid <= 1'b1;
            state     <= ST_RSP;
          end
        ST_WB: begin
          rsp_err   <= ERR_OK;
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RSP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: randomized self-checking bench; expected timing per command is derived from the opcode, operand and done delay
module tb_calc_seq_ctrl;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int TO = 16;
  localparam int CW = $clog2(TO + 1);
  logic l_clk = 1'b0;
  logic ff_rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [OW-1:0] cmd_op = '0;
  logic [DW-1:0] cmd_b = '0;
  logic cmd_acc = 1'b0, acc_sel;
  logic opa_en, opb_en, res_en, alu_start, rsp_valid;
  logic [OW-1:0] alu_op;
  logic alu_done = 1'b0, rsp_ready = 1'b0;
  logic [1:0] rsp_err;
  logic [1:0] prev_err = 2'd0;
  int total = 0;
  int bad = 0;

  calc_seq_ctrl #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .l_clk    (l_clk),
    .ff_rst   (ff_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_b    (cmd_b),
`ifdef CALC_ACC_EN
    .cmd_acc  (cmd_acc),
    .acc_sel  (acc_sel),
`endif
    .opa_en   (opa_en),
    .opb_en   (opb_en),
    .res_en   (res_en),
    .alu_op   (alu_op),
    .alu_start(alu_start),
    .alu_done (alu_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_err  (rsp_err)
  );

`ifndef CALC_ACC_EN
  assign acc_sel = 1'b0;
`endif

  always #5 l_clk = ~l_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_en"}, {opa_en, opb_en, res_en, alu_start, rsp_valid}, 0);
    check({tag, "_err"}, rsp_err, 0);
    check({tag, "_op"}, alu_op, 0);
    check({tag, "_acc"}, acc_sel, 0);
  endtask

  task automatic idle_cycle();
    @(negedge l_clk);
    cmd_valid = 1'b0;
    cmd_op = OW'($urandom);
    alu_done = 1'($urandom);
    rsp_ready = 1'($urandom);
    #1;
    check("idle_ready", cmd_ready, 1);
    check("idle_rsp", rsp_valid, 0);
    check("idle_en", {opa_en, opb_en, res_en, alu_start}, 0);
    check("idle_err", rsp_err, prev_err);
  endtask

  // n: cycles from alu_start to alu_done (0 = never); hold: cycles rsp_ready stays low once rsp_valid rises
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] b, input logic acc,
                         input int n, input int hold, input logic noise);
    bit fault, multi, in_wait;
    logic [1:0] err;
    int start_k, res_k, rsp_k;
    fault = (op == 3'd7) || (op == 3'd6 && b == 0);
    multi = (op == 3'd5) || (op == 3'd6);
    start_k = -1;
    res_k = -1;
    if (op == 3'd7) begin
      err = 2'd3;
      rsp_k = 1;
    end else if (fault) begin
      err = 2'd1;
      rsp_k = 1;
    end else begin
      start_k = 1;
      if (!multi) begin
        res_k = 2;
        rsp_k = 3;
        err = 2'd0;
      end else if (n >= 1 && n <= TO) begin
        res_k = 2 + n;
        rsp_k = 3 + n;
        err = 2'd0;
      end else begin
        rsp_k = 2 + TO;
        err = 2'd2;
      end
    end
    for (int k = 0; k <= rsp_k + hold; k++) begin
      @(negedge l_clk);
      in_wait = multi && !fault && k >= 2 && k <= ((err == 2'd0) ? 1 + n : rsp_k - 1);
      cmd_valid = (k == 0) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      cmd_op = (k == 0) ? op : OW'($urandom);
      cmd_b = (k == 0) ? b : $urandom;
      cmd_acc = (k == 0) ? acc : 1'($urandom);
      alu_done = in_wait ? (k == 1 + n) : (noise & 1'($urandom));
      rsp_ready = (k < rsp_k) ? 1'($urandom) : (k == rsp_k + hold);
      #1;
      if (k == 0) begin
        check("acc_ready", cmd_ready, 1);
        check("acc_opa", opa_en, !fault);
        check("acc_opb", opb_en, !fault);
        check("acc_err_hold", rsp_err, prev_err);
`ifdef CALC_ACC_EN
        check("acc_sel", acc_sel, !fault && acc);
`endif
      end else begin
        check("busy_ready", cmd_ready, 0);
        check("busy_opab", {opa_en, opb_en}, 0);
        check("busy_acc", acc_sel, 0);
      end
      check("alu_start", alu_start, k == start_k);
      check("res_en", res_en, k == res_k);
      check("rsp_valid", rsp_valid, k >= rsp_k);
      if (k >= rsp_k) check("rsp_err", rsp_err, err);
      if (k == start_k) check("alu_op", alu_op, op);
    end
    prev_err = err;
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge l_clk);
    ff_rst = 1'b0;
    #1;
    check_reset_outputs("post_reset");
    run_cmd(3'd0, 32'd7, 1'b1, 0, 0, 1'b0);
    idle_cycle();
    run_cmd(3'd5, 32'd3, 1'b0, 5, 0, 1'b1);
    run_cmd(3'd6, 32'd0, 1'b0, 0, 0, 1'b1);
    run_cmd(3'd6, 32'd9, 1'b0, 0, 0, 1'b0);
    run_cmd(3'd6, 32'd9, 1'b0, TO, 1, 1'b0);
    run_cmd(3'd7, 32'd1, 1'b1, 0, 10, 1'b1);
    idle_cycle();
    // async reset with a held nonzero error
    #2 ff_rst = 1'b1;
    #1 check_reset_outputs("rst_idle");
    @(negedge l_clk);
    ff_rst = 1'b0;
    prev_err = 2'd0;
    // async reset while waiting on a divide
    @(negedge l_clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    cmd_b = 32'd5;
    alu_done = 1'b0;
    #1 check("rst_acc", opa_en, 1);
    repeat (4) begin
      @(negedge l_clk);
      cmd_valid = 1'b0;
    end
    #1 check("rst_wait_op", alu_op, 6);
    #1 ff_rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    @(negedge l_clk);
    ff_rst = 1'b0;
    run_cmd(3'd0, 32'd1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_cmd(op, b, 1'($urandom), $urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
